// File: rtl/cfg_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : cfg_mem_pkg
// Brief  : Shared state encodings and defaults for the config-memory read arbiter.
// Rev    : 1.0
// ============================================================================
package cfg_mem_pkg;

    localparam int MAX_LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cfg_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : cfg_rr_arb2
// Brief  : Two-way round-robin grant; the requester not granted last wins a tie.
// Rev    : 1.0
// ============================================================================
module cfg_rr_arb2
    import cfg_mem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // A requester wins when alone, or when the other one held the last grant.
    assign o_grant[0] = i_req[0] & (~i_req[1] |  i_last_grant);
    assign o_grant[1] = i_req[1] & (~i_req[0] | ~i_last_grant);

endmodule
`default_nettype wire

// File: rtl/cfg_mem_rd_arb.sv
`default_nettype none
// ============================================================================
// Module : cfg_mem_rd_arb
// Brief  : Arbitrates two burst-read requesters onto one single-port memory.
// Rev    : 1.0
// ============================================================================
module cfg_mem_rd_arb
    import cfg_mem_pkg::*;
#(
    parameter int U_DLY     = 1,
    parameter int MAX_LEN_W = MAX_LEN_W_DEF
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [15:0]          req0_addr,
    input  logic [MAX_LEN_W-1:0] req0_len,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [15:0]          req1_addr,
    input  logic [MAX_LEN_W-1:0] req1_len,
    output logic                 req1_ready,
    output logic [31:0]          rd0_data,
    output logic                 rd0_valid,
    output logic [31:0]          rd1_data,
    output logic                 rd1_valid,
    output logic                 done0,
    output logic                 done1,
    output logic                 mem_rd_en,
    output logic [15:0]          mem_rd_addr,
    input  logic [31:0]          mem_rd_data,
    input  logic                 mem_rd_data_valid
);

    localparam logic [MAX_LEN_W:0] c_cnt_one = {{MAX_LEN_W{1'b0}}, 1'b1};

    // The RTL applies no assignment delay; the parameter only fixes its legal range.
    if (U_DLY < 0) begin : g_u_dly_range
    end

    state_e               state_q, state_d;
    logic [15:0]          addr_q, addr_d;
    logic [MAX_LEN_W:0]   len_q, len_d;
    logic [MAX_LEN_W:0]   issue_cnt_q, issue_cnt_d;
    logic [MAX_LEN_W:0]   ret_cnt_q, ret_cnt_d;
    logic                 owner_q, owner_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 rd0_valid_q, rd0_valid_d;
    logic                 rd1_valid_q, rd1_valid_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;

    logic [1:0]           w_grant;
    logic                 w_accept;
    logic                 w_last_ret;
    logic [MAX_LEN_W:0]   w_issue_next;

    cfg_rr_arb2 u_rr_arb (
        .i_req        ({req1_valid, req0_valid}),
        .i_last_grant (owner_q),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            owner_q     <= 1'b1;    // owner doubles as last grant: requester 0 wins first
            rd_data_q   <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            owner_q     <= owner_d;
            rd_data_q   <= rd_data_d;
            rd0_valid_q <= rd0_valid_d;
            rd1_valid_q <= rd1_valid_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        issue_cnt_d  = issue_cnt_q;
        owner_d      = owner_q;
        w_issue_next = issue_cnt_q + c_cnt_one;

        // Returned words only count while a burst is outstanding.
        w_accept    = mem_rd_data_valid && (state_q != ST_IDLE);
        w_last_ret  = w_accept && ((ret_cnt_q + c_cnt_one) == len_q);
        ret_cnt_d   = w_accept ? (ret_cnt_q + c_cnt_one) : ret_cnt_q;
        rd_data_d   = w_accept ? mem_rd_data : rd_data_q;
        rd0_valid_d = w_accept && !owner_q;
        rd1_valid_d = w_accept &&  owner_q;
        done0_d     = w_last_ret && !owner_q;
        done1_d     = w_last_ret &&  owner_q;

        case (state_q)
            ST_IDLE: begin
                if (|w_grant) begin
                    state_d     = ST_ISSUE;
                    owner_d     = w_grant[1];
                    addr_d      = w_grant[1] ? req1_addr : req0_addr;
                    // A zero length field encodes a full 2^MAX_LEN_W burst.
                    len_d       = w_grant[1] ? {(req1_len == '0), req1_len}
                                             : {(req0_len == '0), req0_len};
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                issue_cnt_d = w_issue_next;
                if (w_issue_next == len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_ret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req0_ready  = rst_n && (state_q == ST_IDLE) && w_grant[0];
    assign req1_ready  = rst_n && (state_q == ST_IDLE) && w_grant[1];
    assign mem_rd_en   = (state_q == ST_ISSUE);
    assign mem_rd_addr = addr_q + 16'(issue_cnt_q);
    assign rd0_data    = rd_data_q;
    assign rd1_data    = rd_data_q;
    assign rd0_valid   = rd0_valid_q;
    assign rd1_valid   = rd1_valid_q;
    assign done0       = done0_q;
    assign done1       = done1_q;

endmodule
`default_nettype wire
